pe_mac_bank: RTL and testbench

Parametrised systolic processing element for the NICE CNN accelerator array. Each PE holds a bank of `W_DEPTH` stationary weights instead of a single weight. Weights are daisy-chained down a column, and each activation carries its own weight-select index. Every PE produces one signed multiply-accumulate per cycle, forwards the activation right and the partial sum down, and can optionally saturate the partial sum.

---
 rtl/pe_pkg.sv | 11 +
 rtl/pe_mac_bank_if.sv | 30 +++
 rtl/pe_weight_bank.sv | 65 ++++++
 rtl/pe_mac_bank.sv | 110 +++++++++++
 tb/tb_pe_mac_bank.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the weight-bank systolic PE.
package pe_pkg;

  typedef enum logic {PE_FILL, PE_FULL} pe_load_state_e;

  // Index width for a bank of the given depth; never narrower than one bit.
  function automatic int unsigned wsel_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pe_mac_bank_if.sv
// PE port bundle: load/psum path from above, activation path from the left, and their outputs.
interface pe_mac_bank_if #(
  parameter int unsigned L_WIDTH = 32,
  parameter int unsigned S_WIDTH = 8,
  parameter int unsigned WSEL_W  = 2
);
  logic                      PE_mode;
  logic                      PE_clr;
  logic                      PE_en_up;
  logic signed [L_WIDTH-1:0] PE_data_up;
  logic                      PE_en_left;
  logic signed [S_WIDTH-1:0] PE_data_left;
  logic [WSEL_W-1:0]         PE_wsel_left;
  logic                      PE_en_down;
  logic signed [L_WIDTH-1:0] PE_data_down;
  logic                      PE_en_right;
  logic signed [S_WIDTH-1:0] PE_data_right;
  logic [WSEL_W-1:0]         PE_wsel_right;
  logic                      PE_load_done;

  modport slave (
    input  PE_mode, PE_clr, PE_en_up, PE_data_up, PE_en_left, PE_data_left, PE_wsel_left,
    output PE_en_down, PE_data_down, PE_en_right, PE_data_right, PE_wsel_right, PE_load_done
  );

  modport master (
    output PE_mode, PE_clr, PE_en_up, PE_data_up, PE_en_left, PE_data_left, PE_wsel_left,
    input  PE_en_down, PE_data_down, PE_en_right, PE_data_right, PE_wsel_right, PE_load_done
  );
endinterface

// File: rtl/pe_weight_bank.sv
// Stationary weight register file with FILL/FULL load FSM, write pointer and synchronous clear.
module pe_weight_bank
  import pe_pkg::*;
#(
  parameter int unsigned S_WIDTH = 8,
  parameter int unsigned W_DEPTH = 4,
  parameter int unsigned WSEL_W  = wsel_width(W_DEPTH)
) (
  input  logic                      PE_clk,
  input  logic                      PE_rst_n,
  input  logic                      clr_i,
  input  logic                      wr_en_i,
  input  logic signed [S_WIDTH-1:0] wr_data_i,
  input  logic [WSEL_W-1:0]         rd_idx_i,
  output logic signed [S_WIDTH-1:0] rd_data_o,
  output logic                      full_o
);

  localparam logic [WSEL_W-1:0] LastPtr = WSEL_W'(W_DEPTH - 1);

  logic signed [S_WIDTH-1:0] bank_q [W_DEPTH];
  logic signed [S_WIDTH-1:0] bank_d [W_DEPTH];
  logic [WSEL_W-1:0]         wr_ptr_q, wr_ptr_d;
  pe_load_state_e            state_q, state_d;

  always_comb begin
    bank_d   = bank_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    if (clr_i) begin
      for (int i = 0; i < int'(W_DEPTH); i++) bank_d[i] = '0;
      wr_ptr_d = '0;
      state_d  = PE_FILL;
    end else if (wr_en_i && (state_q == PE_FILL)) begin
      bank_d[wr_ptr_q] = wr_data_i;
      if (wr_ptr_q == LastPtr) begin
        wr_ptr_d = '0;
        state_d  = PE_FULL;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      for (int i = 0; i < int'(W_DEPTH); i++) bank_q[i] <= '0;
      wr_ptr_q <= '0;
      state_q  <= PE_FILL;
    end else begin
      bank_q   <= bank_d;
      wr_ptr_q <= wr_ptr_d;
      state_q  <= state_d;
    end
  end

  // Indices past the bank read as a zero weight.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_idx_i) < int'(W_DEPTH)) rd_data_o = bank_q[rd_idx_i];
  end

  assign full_o = (state_q == PE_FULL);

endmodule

// File: rtl/pe_mac_bank.sv
// Systolic PE with a multi-entry weight bank; optional partial-sum saturation via `PE_SAT_EN.
module pe_mac_bank
  import pe_pkg::*;
#(
  parameter int unsigned L_WIDTH = 32,
  parameter int unsigned S_WIDTH = 8,
  parameter int unsigned W_DEPTH = 4,
  parameter int unsigned WSEL_W  = wsel_width(W_DEPTH)
) (
  input logic          PE_clk,
  input logic          PE_rst_n,
  pe_mac_bank_if.slave bus
);

  logic signed [S_WIDTH-1:0]   weight;
  logic                        bank_full;
  logic signed [2*S_WIDTH-1:0] prod;
  logic signed [L_WIDTH-1:0]   mac_sum;
  logic                        load_acc, comp_acc;

  logic                      en_down_q, en_down_d;
  logic signed [L_WIDTH-1:0] data_down_q, data_down_d;
  logic                      en_right_q, en_right_d;
  logic signed [S_WIDTH-1:0] data_right_q, data_right_d;
  logic [WSEL_W-1:0]         wsel_right_q, wsel_right_d;

  assign load_acc = bus.PE_mode & bus.PE_en_up;
  assign comp_acc = ~bus.PE_mode & bus.PE_en_left;

  pe_weight_bank #(
    .S_WIDTH (S_WIDTH),
    .W_DEPTH (W_DEPTH),
    .WSEL_W  (WSEL_W)
  ) u_bank (
    .PE_clk    (PE_clk),
    .PE_rst_n  (PE_rst_n),
    .clr_i     (bus.PE_clr),
    .wr_en_i   (load_acc),
    .wr_data_i (bus.PE_data_up[S_WIDTH-1:0]),
    .rd_idx_i  (bus.PE_wsel_left),
    .rd_data_o (weight),
    .full_o    (bank_full)
  );

  assign prod = bus.PE_data_left * weight;

`ifdef PE_SAT_EN
  localparam logic signed [L_WIDTH-1:0] SumMax = {1'b0, {(L_WIDTH-1){1'b1}}};
  localparam logic signed [L_WIDTH-1:0] SumMin = {1'b1, {(L_WIDTH-1){1'b0}}};
  logic signed [L_WIDTH:0] sum_wide;

  assign sum_wide = (L_WIDTH+1)'(prod) + (L_WIDTH+1)'(bus.PE_data_up);

  // Top two bits disagree only when the true sum left the L_WIDTH range.
  always_comb begin
    mac_sum = sum_wide[L_WIDTH-1:0];
    if (sum_wide[L_WIDTH] != sum_wide[L_WIDTH-1]) begin
      mac_sum = sum_wide[L_WIDTH] ? SumMin : SumMax;
    end
  end
`else
  assign mac_sum = L_WIDTH'(prod) + bus.PE_data_up;
`endif

  always_comb begin
    en_down_d    = 1'b0;
    en_right_d   = 1'b0;
    data_down_d  = data_down_q;
    data_right_d = data_right_q;
    wsel_right_d = wsel_right_q;
    if (bus.PE_clr) begin
      // Clear wins; data registers hold.
    end else if (load_acc) begin
      if (bank_full) begin
        data_down_d = bus.PE_data_up;
        en_down_d   = 1'b1;
      end
    end else if (comp_acc) begin
      data_right_d = bus.PE_data_left;
      wsel_right_d = bus.PE_wsel_left;
      en_right_d   = 1'b1;
      data_down_d  = mac_sum;
      en_down_d    = 1'b1;
    end
  end

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      en_down_q    <= 1'b0;
      data_down_q  <= '0;
      en_right_q   <= 1'b0;
      data_right_q <= '0;
      wsel_right_q <= '0;
    end else begin
      en_down_q    <= en_down_d;
      data_down_q  <= data_down_d;
      en_right_q   <= en_right_d;
      data_right_q <= data_right_d;
      wsel_right_q <= wsel_right_d;
    end
  end

  assign bus.PE_en_down    = en_down_q;
  assign bus.PE_data_down  = data_down_q;
  assign bus.PE_en_right   = en_right_q;
  assign bus.PE_data_right = data_right_q;
  assign bus.PE_wsel_right = wsel_right_q;
  assign bus.PE_load_done  = bank_full;

endmodule

// File: tb/tb_pe_mac_bank.sv
// Directed self-checking bench for pe_mac_bank (default parameters, PE_SAT_EN aware).
module tb_pe_mac_bank;

  logic PE_clk;
  logic PE_rst_n;
  int   checks = 0;
  int   errors = 0;

  pe_mac_bank_if #(.L_WIDTH(32), .S_WIDTH(8), .WSEL_W(2)) bus ();

  pe_mac_bank #(
    .L_WIDTH (32),
    .S_WIDTH (8),
    .W_DEPTH (4)
  ) dut (
    .PE_clk   (PE_clk),
    .PE_rst_n (PE_rst_n),
    .bus      (bus)
  );

  initial PE_clk = 1'b0;
  always #5 PE_clk = ~PE_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PE_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en_down"},    bus.PE_en_down, 0);
    check({tag, "_data_down"},  bus.PE_data_down, 0);
    check({tag, "_en_right"},   bus.PE_en_right, 0);
    check({tag, "_data_right"}, bus.PE_data_right, 0);
    check({tag, "_wsel_right"}, bus.PE_wsel_right, 0);
    check({tag, "_load_done"},  bus.PE_load_done, 0);
  endtask

  task automatic compute(input logic signed [7:0] a, input logic [1:0] idx,
                         input logic signed [31:0] up);
    bus.PE_mode = 1'b0; bus.PE_en_up = 1'b0; bus.PE_en_left = 1'b1;
    bus.PE_data_left = a; bus.PE_wsel_left = idx; bus.PE_data_up = up;
  endtask

  logic signed [31:0] load_words [5];
  logic signed [7:0]  stream_a   [5];
  logic [1:0]         stream_idx [5];
  logic signed [31:0] stream_exp [5];

  initial begin
    load_words = '{32'sd3, -32'sd2, 32'sd5, 32'sd7, 32'sd9};
    // Weights 3,-2,5,7; psum in 1000 for every stream step.
    stream_a   = '{8'sd2, -8'sd3, 8'sd4, 8'sd1, -8'sd1};
    stream_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    stream_exp = '{32'sd1006, 32'sd1006, 32'sd1020, 32'sd1007, 32'sd997};

    PE_rst_n = 1'b0;
    bus.PE_mode = 1'b0; bus.PE_clr = 1'b0; bus.PE_en_up = 1'b0; bus.PE_data_up = '0;
    bus.PE_en_left = 1'b0; bus.PE_data_left = '0; bus.PE_wsel_left = '0;
    #3;
    check_all_zero("reset");
    @(negedge PE_clk);
    PE_rst_n = 1'b1;

    // Load four weights, fifth word passes through.
    bus.PE_mode = 1'b1; bus.PE_en_up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.PE_data_up = load_words[i];
      tick();
      check("fill_en_down", bus.PE_en_down, 0);
      if (i == 2) check("done_before_full", bus.PE_load_done, 0);
    end
    check("load_done", bus.PE_load_done, 1);
    bus.PE_data_up = load_words[4];
    tick();
    check("pass_en_down", bus.PE_en_down, 1);
    check("pass_data_down", bus.PE_data_down, 9);
    bus.PE_en_up = 1'b0;
    tick();
    check("idle_en_down", bus.PE_en_down, 0);
    check("idle_data_hold", bus.PE_data_down, 9);

    // en_up in compute mode is ignored.
    bus.PE_mode = 1'b0; bus.PE_en_up = 1'b1; bus.PE_data_up = 32'sd555;
    tick();
    check("wrongmode_en_down", bus.PE_en_down, 0);
    check("wrongmode_en_right", bus.PE_en_right, 0);
    check("wrongmode_hold", bus.PE_data_down, 9);

    compute(-8'sd4, 2'd1, 32'sd100);
    tick();
    check("mac_data_down", bus.PE_data_down, 108);
    check("mac_data_right", bus.PE_data_right, -4);
    check("mac_wsel_right", bus.PE_wsel_right, 1);
    check("mac_en_down", bus.PE_en_down, 1);
    check("mac_en_right", bus.PE_en_right, 1);

    compute(8'sd127, 2'd3, 32'sh7FFF_FFF0);
    tick();
`ifdef PE_SAT_EN
    check("overflow", bus.PE_data_down, 32'h7FFF_FFFF);
`else
    check("overflow", bus.PE_data_down, 32'h8000_0369);
`endif

    for (int i = 0; i < 5; i++) begin
      compute(stream_a[i], stream_idx[i], 32'sd1000);
      tick();
      check("stream_en_down", bus.PE_en_down, 1);
      check("stream_data_down", bus.PE_data_down, stream_exp[i]);
      check("stream_wsel_right", bus.PE_wsel_right, stream_idx[i]);
    end

    // Asynchronous reset mid-stream.
    compute(8'sd5, 2'd2, 32'sd7);
    #2;
    PE_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    check("rst_hold_en_right", bus.PE_en_right, 0);
    bus.PE_en_left = 1'b0;
    @(negedge PE_clk);
    PE_rst_n = 1'b1;
    compute(8'sd127, 2'd3, 32'sd5);
    tick();
    check("post_rst_bank_zero", bus.PE_data_down, 5);

    // Clear after two load words; clear beats a concurrent load word.
    bus.PE_en_left = 1'b0; bus.PE_mode = 1'b1; bus.PE_en_up = 1'b1;
    bus.PE_data_up = 32'sd10; tick();
    bus.PE_data_up = 32'sd20; tick();
    bus.PE_clr = 1'b1; bus.PE_data_up = 32'sd30;
    tick();
    check("clr_en_down", bus.PE_en_down, 0);
    check("clr_load_done", bus.PE_load_done, 0);
    bus.PE_clr = 1'b0;
    compute(8'sd50, 2'd0, 32'sd11);
    tick();
    check("clr_idx0", bus.PE_data_down, 11);
    compute(8'sd50, 2'd1, 32'sd11);
    tick();
    check("clr_idx1", bus.PE_data_down, 11);
    bus.PE_en_left = 1'b0;
    tick();
    check("end_idle_en_down", bus.PE_en_down, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
